// File: rtl/person_counter.sv
// Door occupancy counter: decodes direction from two beam-break sensors
// and keeps a saturating count of people inside.
`ifndef PERSON_COUNTER_DATA_WIDTH
`define PERSON_COUNTER_DATA_WIDTH 8
`endif

module person_counter #(
    parameter int DATA_WIDTH     = `PERSON_COUNTER_DATA_WIDTH,
    parameter int MAX_PERSONS    = (1 << DATA_WIDTH) - 1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  outer_sensor_i,
    input  logic                  inner_sensor_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] person_count_o,
    output logic                  entry_pulse_o,
    output logic                  exit_pulse_o,
    output logic                  error_o,
    output logic                  occupied_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] MAX_CNT = DATA_WIDTH'(MAX_PERSONS);

    typedef enum logic [2:0] {
        IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ABORT
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [1:0]            s1_q, s1_d, s2_q, s2_d;
    logic                  entry_q, entry_d;
    logic                  exit_q, exit_d;
    logic                  err_q, err_d;
    logic                  entry_ev, exit_ev;
    logic [TW-1:0]         timer_inc;
    logic                  in_seq;

    always_comb begin
        s1_d = {outer_sensor_i, inner_sensor_i};
        s2_d = s1_q;
    end

    always_comb begin
        state_d  = state_q;
        entry_ev = 1'b0;
        exit_ev  = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (s2_q)
                    2'b10:   state_d = EN1;
                    2'b01:   state_d = EX1;
                    2'b11:   state_d = ABORT;
                    default: state_d = IDLE;
                endcase
            end
            EN1: begin
                unique case (s2_q)
                    2'b00:   state_d = IDLE;
                    2'b11:   state_d = EN2;
                    2'b01:   state_d = ABORT;
                    default: state_d = EN1;
                endcase
            end
            EN2: begin
                unique case (s2_q)
                    2'b10:   state_d = EN1;
                    2'b01:   state_d = EN3;
                    2'b00:   state_d = ABORT;
                    default: state_d = EN2;
                endcase
            end
            EN3: begin
                unique case (s2_q)
                    2'b00: begin
                        state_d  = IDLE;
                        entry_ev = 1'b1;
                    end
                    2'b11:   state_d = EN2;
                    2'b10:   state_d = ABORT;
                    default: state_d = EN3;
                endcase
            end
            EX1: begin
                unique case (s2_q)
                    2'b00:   state_d = IDLE;
                    2'b11:   state_d = EX2;
                    2'b10:   state_d = ABORT;
                    default: state_d = EX1;
                endcase
            end
            EX2: begin
                unique case (s2_q)
                    2'b01:   state_d = EX1;
                    2'b10:   state_d = EX3;
                    2'b00:   state_d = ABORT;
                    default: state_d = EX2;
                endcase
            end
            EX3: begin
                unique case (s2_q)
                    2'b00: begin
                        state_d = IDLE;
                        exit_ev = 1'b1;
                    end
                    2'b11:   state_d = EX2;
                    2'b01:   state_d = ABORT;
                    default: state_d = EX3;
                endcase
            end
            default: begin
                state_d = (s2_q == 2'b00) ? IDLE : ABORT;
            end
        endcase

        // A stuck half-sequence is abandoned after TIMEOUT_CYCLES idle cycles
        in_seq    = (state_q != IDLE) && (state_q != ABORT);
        timer_inc = timer_q + 1'b1;
        timer_d   = '0;
        if (in_seq && (state_d == state_q)) begin
            if (timer_inc == TIMEOUT_LIM) begin
                state_d = ABORT;
            end else begin
                timer_d = timer_inc;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = (state_d == ABORT) && (state_q != ABORT);
        if (clear_i) begin
            count_d = '0;
        end else if (entry_ev) begin
            if (count_q < MAX_CNT) begin
                count_d = count_q + 1'b1;
                entry_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (exit_ev) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
                exit_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign person_count_o = count_q;
    assign entry_pulse_o  = entry_q;
    assign exit_pulse_o   = exit_q;
    assign error_o        = err_q;
    assign occupied_o     = (count_q != '0);

endmodule
